// File: rtl/mem_arbiter.sv
// Memory arbiter between the game loader and the NES core for one SDRAM port.
// The loader writes through a one-entry buffer issued on 4-clock slot boundaries.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 22,
    parameter int unsigned CNT_W  = 22
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_done,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_busy,
    output logic              ld_overrun,
    input  logic [ADDR_W-1:0] nes_addr,
    input  logic [7:0]        nes_dout,
    input  logic              nes_wr,
    input  logic              cpu_rd,
    input  logic              ppu_rd,
    output logic [1:0]        nes_ce,
    output logic              run_nes,
    output logic              reset_nes,
    output logic [ADDR_W+2:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_din,
    output logic              mem_oeA,
    output logic              mem_oeB,
    output logic              mem_drive,
    output logic [CNT_W-1:0]  wr_count
);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;

    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;

    logic              wr_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_din;

    logic boundary_c;
    logic issue_c;
    logic take_c;
    logic drop_c;
    logic rearm_c;
    logic run_c;

    assign boundary_c = (nes_ce == 2'd3);
    assign run_c      = (state == ST_RUN);
    assign issue_c    = boundary_c && !run_c;
    // A write issued this cycle frees the buffer, so a coincident request still fits.
    assign take_c     = ld_req && (!buf_valid || issue_c);
    assign drop_c     = ld_req && buf_valid && !issue_c;
    assign rearm_c    = run_c && (state_nxt == ST_LOAD);

    // Next-state logic; RUN is only entered once no loader write is pending or in flight.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: begin
                if (load_done) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!load_done)
                    state_nxt = ST_LOAD;
                else if (boundary_c && !buf_valid && !wr_we)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (boundary_c && !load_done) state_nxt = ST_LOAD;
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_LOAD;
            nes_ce     <= 2'd0;
            run_nes    <= 1'b0;
            buf_valid  <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= 8'd0;
            wr_we      <= 1'b0;
            wr_addr    <= '0;
            wr_din     <= 8'd0;
            wr_count   <= '0;
            ld_overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            nes_ce  <= nes_ce + 2'd1;
            run_nes <= (nes_ce == 2'd2);

            // Write port reloads every boundary outside RUN and holds for one slot.
            if (issue_c) begin
                wr_we   <= buf_valid;
                wr_addr <= buf_addr;
                wr_din  <= buf_data;
                if (buf_valid) wr_count <= wr_count + CNT_W'(1);
            end

            if (take_c) begin
                buf_valid <= 1'b1;
                buf_addr  <= ld_addr;
                buf_data  <= ld_data;
            end else if (issue_c) begin
                buf_valid <= 1'b0;
            end

            if (rearm_c) begin
                wr_count   <= '0;
                ld_overrun <= 1'b0;
            end
            if (drop_c) ld_overrun <= 1'b1;
        end
    end

    assign ld_busy   = buf_valid;
    assign reset_nes = reset || !run_c;
    assign mem_addr  = run_c ? {3'b000, nes_addr} : {3'b000, wr_addr};
    assign mem_we    = run_c ? nes_wr : wr_we;
    assign mem_din   = run_c ? nes_dout : wr_din;
    assign mem_oeA   = run_c && cpu_rd;
    assign mem_oeB   = run_c && ppu_rd;
    assign mem_drive = mem_we;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 22: loader and NES byte-address width.
REQ-002 Parameter CNT_W, default 22: width of the loader write counter.
REQ-003 Port clock  in  1: single clock (NES system clock). All logic SHALL be on its rising edge.
REQ-004 Port reset  in  1: synchronous, active-high reset.
REQ-005 Port load_done  in  1: game loader finished; 0 means load or reload is in progress.
REQ-006 Port ld_req  in  1: one-cycle loader write strobe.
REQ-007 Port ld_addr  in  ADDR_W: loader write address.
REQ-008 Port ld_data  in  8: loader write data.
REQ-009 Port ld_busy  out  1: loader buffer full.
REQ-010 Port ld_overrun  out  1: sticky flag; a loader write was dropped.
REQ-011 Port nes_addr  in  ADDR_W: NES memory address.
REQ-012 Port nes_dout  in  8: NES write data.
REQ-013 Port nes_wr  in  1: NES write request.
REQ-014 Port cpu_rd  in  1: CPU read request.
REQ-015 Port ppu_rd  in  1: PPU read request.
REQ-016 Port nes_ce  out  2: slot phase counter.
REQ-017 Port run_nes  out  1: NES clock enable.
REQ-018 Port reset_nes  out  1: NES core reset.
REQ-019 Port mem_addr  out  ADDR_W+3: SDRAM controller address, upper 3 bits always 0.
REQ-020 Port mem_we  out  1: SDRAM controller write enable.
REQ-021 Port mem_din  out  8: SDRAM controller write data.
REQ-022 Port mem_oeA  out  1: SDRAM controller CPU read enable.
REQ-023 Port mem_oeB  out  1: SDRAM controller PPU read enable.
REQ-024 Port mem_drive  out  1: SDRAM data-bus drive enable.
REQ-025 Port wr_count  out  CNT_W: number of loader writes issued.

Function
REQ-026 nes_ce SHALL increment by 1 every clock and wrap from 3 to 0; run_nes SHALL equal (nes_ce==3); a "slot boundary" is any cycle with nes_ce==3.
REQ-027 FSM states SHALL be LOAD, DRAIN and RUN; reset_nes SHALL equal reset OR (state!=RUN).
REQ-028 LOAD->DRAIN SHALL occur when load_done==1.
REQ-029 DRAIN->RUN SHALL occur at the first slot boundary with the buffer empty and no loader write in the current slot.
REQ-030 RUN->LOAD SHALL occur at a slot boundary with load_done==0; wr_count and ld_overrun SHALL clear on this transition.
REQ-031 DRAIN->LOAD SHALL occur if load_done returns to 0.
REQ-032 Loader buffer: one entry (addr, data, valid); ld_busy SHALL equal valid.
REQ-033 ld_req with the buffer empty SHALL capture ld_addr/ld_data and set valid on the next cycle.
REQ-034 ld_req with the buffer full and no issue in the same cycle SHALL drop the data and set ld_overrun.
REQ-035 ld_req is accepted in any state; in RUN, an accepted write SHALL be held until the next LOAD.
REQ-036 Issue, in LOAD or DRAIN only: at a slot boundary, the registered write port SHALL be loaded from the buffer, with mem_we set to the buffer's valid bit; valid SHALL clear and wr_count SHALL increment by 1 (wrapping) when valid was 1.
REQ-037 mem_we, and its registered address/data, SHALL hold for exactly 4 clocks (one slot).
REQ-038 ld_req in the same cycle as an issue SHALL capture the new entry (valid stays 1), with no overrun.
REQ-039 In RUN: mem_addr={3'b0,nes_addr}, mem_we=nes_wr, mem_din=nes_dout, mem_oeA=cpu_rd, mem_oeB=ppu_rd, all combinational.
REQ-040 In LOAD/DRAIN: mem_oeA=mem_oeB=0, and mem_addr/mem_we/mem_din SHALL come from the registered write port.
REQ-041 mem_drive SHALL equal mem_we in all states.

Reset
REQ-042 While reset=1, and on the first cycle after it is released: state=LOAD, nes_ce=0, run_nes=0, reset_nes=1, buffer empty, ld_busy=0, ld_overrun=0, registered write port cleared, mem_we=0, mem_drive=0, mem_oeA=mem_oeB=0, mem_addr=0, mem_din=0, wr_count=0.
REQ-043 Reset mid-write SHALL abort the write: mem_we=0 on the next cycle and buffered data discarded.

Verification
REQ-044 Release reset, load_done=0, ld_req at nes_ce=0 with addr 0x000010, data 0xA5 -> at the next boundary mem_addr=0x0000010, mem_din=0xA5, mem_we=mem_drive=1 for 4 clocks; wr_count=1.
REQ-045 Two ld_req 1 clock apart, both before a boundary -> second dropped, ld_overrun=1, only the first is written.
REQ-046 ld_req coincident with issue at nes_ce=3 -> first written now, second written at the next boundary, ld_overrun=0, wr_count=2.
REQ-047 Buffer full, then load_done rises -> state=DRAIN, buffered write issued, RUN entered at a later boundary; reset_nes falls only then; cpu_rd=1 then gives mem_oeA=1 on the same cycle.
REQ-048 In RUN, drop load_done -> LOAD at the next boundary, reset_nes=1, mem_oeA/mem_oeB=0, wr_count=0.
REQ-049 Assert reset during an active loader write -> next cycle mem_we=0, ld_busy=0, nes_ce=0.
